// File: rtl/nibble_add_seq.sv
// Purpose : sequential multi-precision adder; one shared 4-bit add slice, LS nibble first.
// Latency : start accepted at edge T -> busy for NIBBLES cycles, done pulse in cycle T+NIBBLES+1.
// Backpr. : none; start is sampled only in IDLE and ignored while busy/done.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request an addition (sampled in IDLE only)
//   da, db, dcin    operands and carry-in, captured on an accepted start
//   busy, done      RUN indicator and one-cycle completion pulse (never both high)
//   dsum, dcarry    registered sum and carry-out of the top nibble
module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   da,
    input  logic [4*NIBBLES-1:0]   db,
    input  logic                   dcin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   dsum,
    output logic                   dcarry
);

    localparam int W  = 4 * NIBBLES;
    // A single-nibble build still needs a 1-bit index register.
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;

    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [4:0]    nsum;
    logic          last;

    // Nibble selection from the captured operands by the current index.
    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
                a_nib = a_reg[4*i +: 4];
                b_nib = b_reg[4*i +: 4];
            end
        end
        nsum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
        last = (idx == IW'(NIBBLES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            dsum   <= '0;
            dcarry <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg  <= da;
                        b_reg  <= db;
                        carry  <= dcin;
                        idx    <= '0;
                        dsum   <= '0;
                        dcarry <= 1'b0;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx == IW'(i)) begin
                            dsum[4*i +: 4] <= nsum[3:0];
                        end
                    end
                    carry <= nsum[4];
                    if (last) begin
                        dcarry <= nsum[4];
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
